writeback_unit: RTL and testbench

- Write-back end of the register-file interface. The operand-read stage reads registers; this block is the only writer.
- Accepts results from the ALU and load paths through valid/ready handshakes and buffers them in a small in-order queue.
- Retires one register write per cycle on the register-file write port.
- Exposes a pending-write scoreboard so the operand-read stage can stall on RAW hazards.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/wb_fifo.sv | 75 +++++++
 rtl/writeback_unit.sv | 107 ++++++++++
 tb/tb_writeback_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file constants and the write-back queue entry type.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int ZERO_REG   = 0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic circular FIFO with push/pop/count; exposes its entries ordered oldest-first
// together with a per-slot valid mask so callers can search the whole queue.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 din,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 by_age    [DEPTH],
    output logic [DEPTH-1:0]       age_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            by_age[k]    = mem_q[rd_ptr_q + PTR_W'(k)];
            age_valid[k] = (CNT_W'(k) < count_q);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-back: arbitrates load/ALU results into an in-order queue, retires one
// write per cycle and reports pending writes. Define WB_BYPASS_EN to add youngest-match forwarding.
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   ld_valid,
    input  logic [ADDR_W-1:0]      ld_rd,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   ld_ready,
    output logic                   RegWrite,
    output logic [ADDR_W-1:0]      Write_register,
    output logic [DATA_W-1:0]      Write_data,
    input  logic [ADDR_W-1:0]      Read_register1,
    input  logic [ADDR_W-1:0]      Read_register2,
    output logic                   pending1,
    output logic                   pending2,
`ifdef WB_BYPASS_EN
    output logic [DATA_W-1:0]      fwd_data1,
    output logic [DATA_W-1:0]      fwd_data2,
`endif
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] R0      = ADDR_W'(ZERO_REG);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic             not_full, ld_fire, alu_fire, push, reg_write;
    entry_t           push_entry;
    logic [CNT_W-1:0] count;
    entry_t           by_age [DEPTH];
    logic [DEPTH-1:0] age_valid;

    // Readiness looks only at the current count, so a full queue never accepts even while draining.
    always_comb begin
        not_full        = (count < FULL_CNT);
        ld_ready        = not_full;
        alu_ready       = not_full && !ld_valid;
        ld_fire         = ld_valid && ld_ready;
        alu_fire        = alu_valid && alu_ready;
        push_entry.rd   = ld_fire ? ld_rd   : alu_rd;
        push_entry.data = ld_fire ? ld_data : alu_data;
        push            = (ld_fire || alu_fire) && (push_entry.rd != R0);
    end

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .din       (push_entry),
        .pop       (reg_write),
        .count     (count),
        .by_age    (by_age),
        .age_valid (age_valid)
    );

    always_comb begin
        reg_write      = (count != '0);
        RegWrite       = reg_write;
        Write_register = reg_write ? by_age[0].rd   : '0;
        Write_data     = reg_write ? by_age[0].data : '0;
        occupancy      = count;
    end

    // Scanning oldest to youngest lets the last match win, which is the youngest write.
    always_comb begin
        pending1 = 1'b0;
        pending2 = 1'b0;
`ifdef WB_BYPASS_EN
        fwd_data1 = '0;
        fwd_data2 = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k] && (Read_register1 != R0) && (by_age[k].rd == Read_register1)) begin
                pending1 = 1'b1;
`ifdef WB_BYPASS_EN
                fwd_data1 = by_age[k].data;
`endif
            end
            if (age_valid[k] && (Read_register2 != R0) && (by_age[k].rd == Read_register2)) begin
                pending2 = 1'b1;
`ifdef WB_BYPASS_EN
                fwd_data2 = by_age[k].data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: queue-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_writeback_unit;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0, ld_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0, ld_rd = '0;
    logic [DW-1:0] alu_data = '0, ld_data = '0;
    logic [AW-1:0] Read_register1 = '0, Read_register2 = '0;
    logic          alu_ready, ld_ready, RegWrite, pending1, pending2;
    logic [AW-1:0] Write_register;
    logic [DW-1:0] Write_data;
    logic [$clog2(DEPTH):0] occupancy;
`ifdef WB_BYPASS_EN
    logic [DW-1:0] fwd_data1, fwd_data2;
`endif

    always #5 clk = ~clk;

    writeback_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .ld_valid       (ld_valid),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .Read_register1 (Read_register1),
        .Read_register2 (Read_register2),
        .pending1       (pending1),
        .pending2       (pending2),
`ifdef WB_BYPASS_EN
        .fwd_data1      (fwd_data1),
        .fwd_data2      (fwd_data2),
`endif
        .occupancy      (occupancy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] rf_model [32];
    logic [DW-1:0] rf_dut   [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_pending(input logic [AW-1:0] ra);
        if (ra == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == ra) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] ra);
        logic [DW-1:0] r;
        r = '0;
        if (ra != '0) foreach (mq[i]) if (mq[i].rd == ra) r = mq[i].data;
        return r;
    endfunction

    // Reference model: a plain queue of accepted writes and a 32-entry register file.
    always @(posedge clk or negedge rst_n) begin : model
        bit   room, acc;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
        end else begin
            room = (mq.size() < DEPTH);
            acc  = 1'b0;
            if (ld_valid && room) begin
                acc = 1'b1; e.rd = ld_rd; e.data = ld_data;
            end else if (alu_valid && room) begin
                acc = 1'b1; e.rd = alu_rd; e.data = alu_data;
            end
            if (mq.size() != 0) begin
                rf_model[mq[0].rd] = mq[0].data;
                void'(mq.pop_front());
            end
            if (acc && e.rd != '0) mq.push_back(e);
        end
    end

    always @(posedge clk) begin
        if (rst_n && RegWrite) rf_dut[Write_register] = Write_data;
    end

    always @(negedge clk) begin
        check("regwrite",  RegWrite,       mq.size() != 0);
        check("wr_reg",    Write_register, (mq.size() != 0) ? mq[0].rd   : '0);
        check("wr_data",   Write_data,     (mq.size() != 0) ? mq[0].data : '0);
        check("occupancy", occupancy,      mq.size());
        check("ld_ready",  ld_ready,       mq.size() < DEPTH);
        check("alu_ready", alu_ready,      (mq.size() < DEPTH) && !ld_valid);
        check("pending1",  pending1,       model_pending(Read_register1));
        check("pending2",  pending2,       model_pending(Read_register2));
`ifdef WB_BYPASS_EN
        check("fwd_data1", fwd_data1,      model_fwd(Read_register1));
        check("fwd_data2", fwd_data2,      model_fwd(Read_register2));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 32; r++) begin
            rf_model[r] = '0;
            rf_dut[r]   = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_regwrite", RegWrite, 1'b0);
        check("rst_occ", occupancy, 0);

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF; #1;
        check("single_alu_ready", alu_ready, 1'b1);
        step(); alu_valid = 1'b0; #1;
        check("single_we", RegWrite, 1'b1);
        check("single_addr", Write_register, 5);
        check("single_data", Write_data, 32'hDEADBEEF);
        step();
        check("single_empty", occupancy, 0);

        // Load beats ALU
        ld_valid = 1'b1; ld_rd = 3; ld_data = 32'h33;
        alu_valid = 1'b1; alu_rd = 4; alu_data = 32'h44; #1;
        check("prio_ld_ready", ld_ready, 1'b1);
        check("prio_alu_ready", alu_ready, 1'b0);
        step(); ld_valid = 1'b0; #1;
        check("prio_first", Write_register, 3);
        check("prio_alu_ready2", alu_ready, 1'b1);
        step(); alu_valid = 1'b0; #1;
        check("prio_second", Write_register, 4);
        check("prio_second_data", Write_data, 32'h44);
        step();

        // Back-to-back loads: the head drains every cycle, so occupancy holds at 1
        ld_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ld_rd = AW'(i); ld_data = 32'h100 + i;
            step();
            check("stream_occ", occupancy, 1);
            check("stream_head", Write_register, i);
        end
        ld_valid = 1'b0;
        step();

        // Writes to r0 are accepted and dropped
        alu_valid = 1'b1; alu_rd = 0; alu_data = 32'h1234; #1;
        check("r0_ready", alu_ready, 1'b1);
        step(); alu_valid = 1'b0; #1;
        check("r0_no_write", RegWrite, 1'b0);
        check("r0_occ", occupancy, 0);

        // Scoreboard and last-writer-wins
        Read_register1 = 7; Read_register2 = 0;
        ld_valid = 1'b1; ld_rd = 7; ld_data = 32'h1;
        step();
        check("sb_p1", pending1, 1'b1);
        check("sb_p2_r0", pending2, 1'b0);
        ld_rd = 9; ld_data = 32'h9; Read_register2 = 9;
        step();
        check("sb_p1_fall", pending1, 1'b0);
        check("sb_p2_r9", pending2, 1'b1);
        ld_rd = 7; ld_data = 32'h1;
        step();
        ld_rd = 7; ld_data = 32'h2;
        step();
        check("sb_p1_again", pending1, 1'b1);
`ifdef WB_BYPASS_EN
        check("sb_fwd_young", fwd_data1, 32'h2);
`endif
        ld_valid = 1'b0;
        step(); step();
        check("sb_last_wins", rf_dut[7], 32'h2);
        check("sb_p1_clear", pending1, 1'b0);

        // Asynchronous reset with a write queued
        ld_valid = 1'b1; ld_rd = 12; ld_data = 32'hABC;
        step();
        ld_valid = 1'b0; Read_register1 = 12; #1;
        check("pre_rst_occ", occupancy, 1);
        check("pre_rst_pend", pending1, 1'b1);
        rst_n = 1'b0; #1;
        check("rst_async_we", RegWrite, 1'b0);
        check("rst_async_occ", occupancy, 0);
        check("rst_async_pend", pending1, 1'b0);
        step(); step();
        rst_n = 1'b1;
        step(); step();
        check("post_rst_no_stale", RegWrite, 1'b0);
        check("post_rst_r12", rf_dut[12], 32'h0);

        for (int r = 0; r < 32; r++) check("regfile", rf_dut[r], rf_model[r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
